// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
// Request is held until acknowledged; read data is valid only in the acknowledge cycle.
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [7:0]        dmem_be;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage: branch resolve, data-memory access with lane steering and timeout, MEM/WB register.
// Zero-wait ack retires in one cycle; otherwise mem_stall holds upstream until ack or timeout.
module mem_stage_ctrl #(
    parameter int DATA_W  = 64,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EX_MEM_Branch,
    input  logic              EX_MEM_MemRead,
    input  logic              EX_MEM_MemWrite,
    input  logic              EX_MEM_RegWrite,
    input  logic              EX_MEM_MemtoReg,
    input  logic              EX_MEM_Zero,
    input  logic              EX_MEM_Is_Greater,
    input  logic [3:0]        EX_MEM_funct_in,
    input  logic [RD_W-1:0]   EX_MEM_rd,
    input  logic [DATA_W-1:0] EX_MEM_ALU_Out,
    input  logic [DATA_W-1:0] EX_MEM_MUX_ForwardB,
    input  logic [DATA_W-1:0] EX_MEM_PC_Adder,
    mem_stage_ctrl_if.master  dmem,
    output logic              mem_stall,
    output logic              PCSrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              MEM_WB_RegWrite,
    output logic              MEM_WB_MemtoReg,
    output logic [RD_W-1:0]   MEM_WB_rd,
    output logic [DATA_W-1:0] MEM_WB_ReadData,
    output logic [DATA_W-1:0] MEM_WB_ALU_Out
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic              r_misalign_err, r_bus_err;
    logic              r_wb_regwrite, r_wb_memtoreg;
    logic [RD_W-1:0]   r_wb_rd;
    logic [DATA_W-1:0] r_wb_readdata, r_wb_alu;

    logic [2:0]        w_f3, w_off;
    logic [1:0]        w_size;
    logic              w_access, w_mis, w_misalign, w_go, w_req, w_timeout, w_cond;
    logic [7:0]        w_mask;
    logic [DATA_W-1:0] w_lane, w_load, w_wdata;
    logic              w_unused;

    assign w_f3     = EX_MEM_funct_in[2:0];
    assign w_size   = w_f3[1:0];
    assign w_off    = EX_MEM_ALU_Out[2:0];
    assign w_access = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign w_unused = EX_MEM_funct_in[3];

    always_comb begin
        w_mis  = 1'b0;
        w_mask = 8'hFF;
        case (w_size)
            2'd0:    begin w_mis = 1'b0;         w_mask = 8'h01; end
            2'd1:    begin w_mis = w_off[0];     w_mask = 8'h03; end
            2'd2:    begin w_mis = |w_off[1:0];  w_mask = 8'h0F; end
            default: begin w_mis = |w_off;       w_mask = 8'hFF; end
        endcase
    end

    assign w_misalign = w_access & w_mis;
    // The cycle after a timeout the abandoned access is still in EX/MEM; skip it instead of retrying.
    assign w_go       = w_access & ~w_mis & ~r_bus_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_req = 1'b1;
                    if (!dmem.dmem_ack) begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = 8'd1;
                    end
                end
            end
            S_BUSY: begin
                w_req     = 1'b1;
                w_cnt_nxt = r_cnt + 8'd1;
                if (dmem.dmem_ack) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (w_cnt_nxt == TO_CNT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (reset) w_req = 1'b0;
    end

    assign w_lane = dmem.dmem_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load  = w_lane;
        w_wdata = EX_MEM_MUX_ForwardB;
        case (w_size)
            2'd0: begin
                w_load  = {{(DATA_W-8){~w_f3[2] & w_lane[7]}}, w_lane[7:0]};
                w_wdata = {(DATA_W/8){EX_MEM_MUX_ForwardB[7:0]}};
            end
            2'd1: begin
                w_load  = {{(DATA_W-16){~w_f3[2] & w_lane[15]}}, w_lane[15:0]};
                w_wdata = {(DATA_W/16){EX_MEM_MUX_ForwardB[15:0]}};
            end
            2'd2: begin
                w_load  = {{(DATA_W-32){~w_f3[2] & w_lane[31]}}, w_lane[31:0]};
                w_wdata = {(DATA_W/32){EX_MEM_MUX_ForwardB[31:0]}};
            end
            default: begin
                w_load  = w_lane;
                w_wdata = EX_MEM_MUX_ForwardB;
            end
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        case (w_f3)
            3'b000:  w_cond = EX_MEM_Zero;
            3'b001:  w_cond = ~EX_MEM_Zero;
            3'b100:  w_cond = ~EX_MEM_Is_Greater & ~EX_MEM_Zero;
            3'b101:  w_cond = EX_MEM_Is_Greater | EX_MEM_Zero;
            default: w_cond = 1'b0;
        endcase
    end

    assign PCSrc         = EX_MEM_Branch & w_cond;
    assign branch_target = EX_MEM_PC_Adder;
    assign mem_stall     = w_req & ~dmem.dmem_ack;

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = w_req & EX_MEM_MemWrite;
    assign dmem.dmem_addr  = {EX_MEM_ALU_Out[DATA_W-1:3], 3'b000};
    assign dmem.dmem_be    = w_req ? (w_mask << w_off) : 8'h00;
    assign dmem.dmem_wdata = w_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 8'd0;
            r_misalign_err <= 1'b0;
            r_bus_err      <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_readdata  <= '0;
            r_wb_alu       <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_misalign_err <= w_misalign;
            r_bus_err      <= w_timeout;
            if (mem_stall || w_misalign || (w_access && r_bus_err)) begin
                r_wb_regwrite <= 1'b0;
                r_wb_memtoreg <= 1'b0;
                r_wb_rd       <= '0;
                r_wb_readdata <= '0;
                r_wb_alu      <= '0;
            end else begin
                r_wb_regwrite <= EX_MEM_RegWrite;
                r_wb_memtoreg <= EX_MEM_MemtoReg;
                r_wb_rd       <= EX_MEM_rd;
                r_wb_readdata <= EX_MEM_MemRead ? w_load : '0;
                r_wb_alu      <= EX_MEM_ALU_Out;
            end
        end
    end

    assign misalign_err    = r_misalign_err;
    assign bus_err         = r_bus_err;
    assign MEM_WB_RegWrite = r_wb_regwrite;
    assign MEM_WB_MemtoReg = r_wb_memtoreg;
    assign MEM_WB_rd       = r_wb_rd;
    assign MEM_WB_ReadData = r_wb_readdata;
    assign MEM_WB_ALU_Out  = r_wb_alu;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: each issued EX/MEM entry queues its expected MEM/WB
// record, popped on the edge where the stage advances (mem_stall low).
module tb_mem_stage_ctrl;
    typedef struct packed {
        logic        br, mr, mw, rw, m2r, z, g;
        logic [3:0]  fn;
        logic [4:0]  rd;
        logic [63:0] alu, fb, pc;
    } ex_t;

    typedef struct packed {
        logic        rw, m2r;
        logic [4:0]  rd;
        logic [63:0] rdat, alu;
    } wb_t;

    logic        clk, reset;
    logic        EX_MEM_Branch, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg;
    logic        EX_MEM_Zero, EX_MEM_Is_Greater;
    logic [3:0]  EX_MEM_funct_in;
    logic [4:0]  EX_MEM_rd;
    logic [63:0] EX_MEM_ALU_Out, EX_MEM_MUX_ForwardB, EX_MEM_PC_Adder;
    logic        mem_stall, PCSrc, misalign_err, bus_err;
    logic [63:0] branch_target;
    logic        MEM_WB_RegWrite, MEM_WB_MemtoReg;
    logic [4:0]  MEM_WB_rd;
    logic [63:0] MEM_WB_ReadData, MEM_WB_ALU_Out;

    mem_stage_ctrl_if #(.DATA_W(64)) dmem_if ();

    mem_stage_ctrl #(.DATA_W(64), .RD_W(5), .TIMEOUT(255)) dut (
        .clk                 (clk),
        .reset               (reset),
        .EX_MEM_Branch       (EX_MEM_Branch),
        .EX_MEM_MemRead      (EX_MEM_MemRead),
        .EX_MEM_MemWrite     (EX_MEM_MemWrite),
        .EX_MEM_RegWrite     (EX_MEM_RegWrite),
        .EX_MEM_MemtoReg     (EX_MEM_MemtoReg),
        .EX_MEM_Zero         (EX_MEM_Zero),
        .EX_MEM_Is_Greater   (EX_MEM_Is_Greater),
        .EX_MEM_funct_in     (EX_MEM_funct_in),
        .EX_MEM_rd           (EX_MEM_rd),
        .EX_MEM_ALU_Out      (EX_MEM_ALU_Out),
        .EX_MEM_MUX_ForwardB (EX_MEM_MUX_ForwardB),
        .EX_MEM_PC_Adder     (EX_MEM_PC_Adder),
        .dmem                (dmem_if),
        .mem_stall           (mem_stall),
        .PCSrc               (PCSrc),
        .branch_target       (branch_target),
        .misalign_err        (misalign_err),
        .bus_err             (bus_err),
        .MEM_WB_RegWrite     (MEM_WB_RegWrite),
        .MEM_WB_MemtoReg     (MEM_WB_MemtoReg),
        .MEM_WB_rd           (MEM_WB_rd),
        .MEM_WB_ReadData     (MEM_WB_ReadData),
        .MEM_WB_ALU_Out      (MEM_WB_ALU_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_chk, n_pass;
    wb_t sb[$];

    int          stall_cnt, n_bus, n_mis;
    logic        c_req, c_we, c_pcsrc;
    logic [7:0]  c_be;
    logic [63:0] c_wdata, c_addr, c_tgt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic ex_t mk_mem(logic mr, logic mw, logic [2:0] f3, logic [4:0] rd,
                                   logic [63:0] alu, logic [63:0] fb);
        ex_t e;
        e = '0;
        e.mr = mr; e.mw = mw; e.rw = mr; e.m2r = mr;
        e.fn = {1'b0, f3}; e.rd = rd; e.alu = alu; e.fb = fb;
        return e;
    endfunction

    function automatic ex_t mk_br(logic br, logic [2:0] f3, logic z, logic g, logic [63:0] pc);
        ex_t e;
        e = '0;
        e.br = br; e.fn = {1'b0, f3}; e.z = z; e.g = g; e.pc = pc;
        e.rd = 5'd3; e.alu = 64'h55;
        return e;
    endfunction

    function automatic wb_t mk_wb(logic rw, logic m2r, logic [4:0] rd, logic [63:0] rdat, logic [63:0] alu);
        wb_t w;
        w.rw = rw; w.m2r = m2r; w.rd = rd; w.rdat = rdat; w.alu = alu;
        return w;
    endfunction

    // Byte-wise reference for load extraction and extension.
    function automatic logic [63:0] ld_model(logic [63:0] d, logic [2:0] off, logic [2:0] f3);
        logic [63:0] r;
        int n;
        r = '0;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) r[8*i +: 8] = d[8*(int'(off)+i) +: 8];
        if (!f3[2] && r[8*n-1]) for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic apply(input ex_t e);
        EX_MEM_Branch = e.br; EX_MEM_MemRead = e.mr; EX_MEM_MemWrite = e.mw;
        EX_MEM_RegWrite = e.rw; EX_MEM_MemtoReg = e.m2r; EX_MEM_Zero = e.z;
        EX_MEM_Is_Greater = e.g; EX_MEM_funct_in = e.fn; EX_MEM_rd = e.rd;
        EX_MEM_ALU_Out = e.alu; EX_MEM_MUX_ForwardB = e.fb; EX_MEM_PC_Adder = e.pc;
    endtask

    // Called just after a rising edge; returns just after the retiring edge.
    task automatic run(input ex_t e, input int ack_lat, input logic [63:0] rdata, input wb_t exp);
        logic st, done;
        wb_t  w;
        apply(e);
        sb.push_back(exp);
        stall_cnt = 0; n_bus = 0; n_mis = 0; done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            dmem_if.dmem_ack   = (cyc == ack_lat);
            dmem_if.dmem_rdata = (cyc == ack_lat) ? rdata : 64'hDEAD_BEEF_0BAD_F00D;
            #3;
            st = mem_stall;
            if (cyc == 0) begin
                c_req = dmem_if.dmem_req; c_we = dmem_if.dmem_we; c_be = dmem_if.dmem_be;
                c_wdata = dmem_if.dmem_wdata; c_addr = dmem_if.dmem_addr;
                c_pcsrc = PCSrc; c_tgt = branch_target;
            end
            if (st) stall_cnt++;
            @(posedge clk);
            #1;
            if (bus_err) n_bus++;
            if (misalign_err) n_mis++;
            if (!st) begin
                w = sb.pop_front();
                check("wb_regwrite", 64'(MEM_WB_RegWrite), 64'(w.rw));
                check("wb_memtoreg", 64'(MEM_WB_MemtoReg), 64'(w.m2r));
                check("wb_rd",       64'(MEM_WB_rd),       64'(w.rd));
                check("wb_readdata", MEM_WB_ReadData,      w.rdat);
                check("wb_alu",      MEM_WB_ALU_Out,       w.alu);
                done = 1'b1;
            end else begin
                check("stall_bubble", 64'(MEM_WB_RegWrite), 64'd0);
            end
        end
        dmem_if.dmem_ack = 1'b0;
        check("retired", 64'(done), 64'd1);
    endtask

    ex_t         e;
    wb_t         x;
    logic [1:0]  sz;
    logic [2:0]  off, f3;
    logic        st_op;
    int          n, lat;
    logic [63:0] rd_v, fb_v, alu_v, wd_m;
    logic [7:0]  be_m;

    initial begin
        n_chk = 0; n_pass = 0;
        dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;
        reset = 1'b1;
        apply(mk_mem(1'b1, 1'b0, 3'b011, 5'd1, 64'h1000, 64'h0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",      64'(dmem_if.dmem_req), 64'd0);
        check("rst_stall",    64'(mem_stall),        64'd0);
        check("rst_regwrite", 64'(MEM_WB_RegWrite),  64'd0);
        check("rst_readdata", MEM_WB_ReadData,       64'd0);
        check("rst_errs",     64'({bus_err, misalign_err}), 64'd0);
        reset = 1'b0;

        // ld, zero-wait ack
        run(mk_mem(1'b1, 1'b0, 3'b011, 5'd10, 64'h1000, 64'h0), 0, 64'h1122334455667788,
            mk_wb(1'b1, 1'b1, 5'd10, 64'h1122334455667788, 64'h1000));
        check("ld_stalls", 64'(stall_cnt), 64'd0);
        check("ld_addr", c_addr, 64'h1000);

        // lb / lbu with ack after 3 cycles
        run(mk_mem(1'b1, 1'b0, 3'b000, 5'd11, 64'h1003, 64'h0), 3, 64'h11223344_80665577,
            mk_wb(1'b1, 1'b1, 5'd11, 64'hFFFF_FFFF_FFFF_FF80, 64'h1003));
        check("lb_stalls", 64'(stall_cnt), 64'd3);
        check("lb_addr", c_addr, 64'h1000);
        run(mk_mem(1'b1, 1'b0, 3'b100, 5'd12, 64'h1003, 64'h0), 3, 64'h11223344_80665577,
            mk_wb(1'b1, 1'b1, 5'd12, 64'h80, 64'h1003));
        check("lbu_stalls", 64'(stall_cnt), 64'd3);

        // sh to upper halfword lane
        run(mk_mem(1'b0, 1'b1, 3'b001, 5'd0, 64'h2006, 64'h1234_5678_9ABC_ABCD), 0, 64'h0,
            mk_wb(1'b0, 1'b0, 5'd0, 64'h0, 64'h2006));
        check("sh_be",    64'(c_be),  64'hC0);
        check("sh_wdata", c_wdata,    64'hABCD_ABCD_ABCD_ABCD);
        check("sh_we",    64'(c_we),  64'd1);
        check("sh_addr",  c_addr,     64'h2000);

        // lw misaligned
        run(mk_mem(1'b1, 1'b0, 3'b010, 5'd13, 64'h2002, 64'h0), 0, 64'h0, wb_t'('0));
        check("mis_req",    64'(c_req),     64'd0);
        check("mis_stalls", 64'(stall_cnt), 64'd0);
        check("mis_pulse",  64'(n_mis),     64'd1);

        // load never acknowledged
        run(mk_mem(1'b1, 1'b0, 3'b011, 5'd14, 64'h3000, 64'h0), -1, 64'h0, wb_t'('0));
        check("to_req",    64'(c_req),     64'd1);
        check("to_stalls", 64'(stall_cnt), 64'd255);
        check("to_buserr", 64'(n_bus),     64'd1);

        // ALU op with a stray ack
        run(mk_br(1'b0, 3'b000, 1'b0, 1'b0, 64'h0), 0, 64'hFFFF, mk_wb(1'b0, 1'b0, 5'd3, 64'h0, 64'h55));
        e = '0; e.rw = 1'b1; e.rd = 5'd7; e.alu = 64'hCAFE;
        run(e, 0, 64'h1234, mk_wb(1'b1, 1'b0, 5'd7, 64'h0, 64'hCAFE));
        check("alu_stalls", 64'(stall_cnt), 64'd0);
        check("alu_req",    64'(c_req),     64'd0);

        // branches
        x = mk_wb(1'b0, 1'b0, 5'd3, 64'h0, 64'h55);
        run(mk_br(1'b1, 3'b000, 1'b1, 1'b0, 64'h40), 0, 64'h0, x);
        check("beq_taken", 64'(c_pcsrc), 64'd1);
        check("beq_tgt",   c_tgt,        64'h40);
        run(mk_br(1'b1, 3'b101, 1'b0, 1'b0, 64'h80), 0, 64'h0, x);
        check("bge_not",   64'(c_pcsrc), 64'd0);
        run(mk_br(1'b1, 3'b101, 1'b0, 1'b1, 64'h80), 0, 64'h0, x);
        check("bge_taken", 64'(c_pcsrc), 64'd1);
        run(mk_br(1'b1, 3'b001, 1'b0, 1'b0, 64'h90), 0, 64'h0, x);
        check("bne_taken", 64'(c_pcsrc), 64'd1);
        run(mk_br(1'b1, 3'b100, 1'b0, 1'b0, 64'h90), 0, 64'h0, x);
        check("blt_taken", 64'(c_pcsrc), 64'd1);
        run(mk_br(1'b1, 3'b100, 1'b1, 1'b0, 64'h90), 0, 64'h0, x);
        check("blt_not",   64'(c_pcsrc), 64'd0);
        run(mk_br(1'b1, 3'b010, 1'b1, 1'b1, 64'h90), 0, 64'h0, x);
        check("bunk_not",  64'(c_pcsrc), 64'd0);
        run(mk_br(1'b0, 3'b000, 1'b1, 1'b0, 64'h90), 0, 64'h0, x);
        check("nobr_not",  64'(c_pcsrc), 64'd0);

        // random aligned loads and stores
        for (int k = 0; k < 12; k++) begin
            sz    = 2'($urandom_range(0, 3));
            n     = 1 << sz;
            off   = 3'(($urandom_range(0, 7) / n) * n);
            st_op = 1'($urandom_range(0, 1));
            f3    = {1'($urandom_range(0, 1)), sz};
            lat   = $urandom_range(0, 3);
            rd_v  = {$urandom, $urandom};
            fb_v  = {$urandom, $urandom};
            alu_v = {$urandom, $urandom};
            alu_v[2:0] = off;
            be_m  = 8'(((1 << n) - 1) << off);
            for (int i = 0; i < 8; i++) wd_m[8*i +: 8] = fb_v[8*(i % n) +: 8];
            e = mk_mem(~st_op, st_op, f3, 5'(k + 1), alu_v, fb_v);
            if (st_op) x = mk_wb(1'b0, 1'b0, 5'(k + 1), 64'h0, alu_v);
            else       x = mk_wb(1'b1, 1'b1, 5'(k + 1), ld_model(rd_v, off, f3), alu_v);
            run(e, lat, rd_v, x);
            check("rnd_stalls", 64'(stall_cnt), 64'(lat));
            check("rnd_be", 64'(c_be), 64'(be_m));
            if (st_op) check("rnd_wdata", c_wdata, wd_m);
        end

        // reset while BUSY
        apply(mk_mem(1'b1, 1'b0, 3'b011, 5'd20, 64'h4000, 64'h0));
        dmem_if.dmem_ack = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("busy_stall", 64'(mem_stall), 64'd1);
        reset = 1'b1;
        #1;
        check("rstbusy_req",   64'(dmem_if.dmem_req), 64'd0);
        check("rstbusy_stall", 64'(mem_stall),        64'd0);
        check("rstbusy_wb",    64'({MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_rd}), 64'd0);
        check("rstbusy_err",   64'({bus_err, misalign_err}), 64'd0);
        apply('0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(mk_mem(1'b1, 1'b0, 3'b011, 5'd21, 64'h4000, 64'h0), 0, 64'h0BAD_CAFE,
            mk_wb(1'b1, 1'b1, 5'd21, 64'h0BAD_CAFE, 64'h4000));
        check("post_rst_stalls", 64'(stall_cnt), 64'd0);
        check("post_rst_buserr", 64'(n_bus),     64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
